// File: rtl/hpm_counter_bank.sv
// Bank of machine HPM counters (mhpmcounter3+k / mhpmevent3+k) with event masks,
// mcountinhibit, sticky overflow flags, overflow enables and a registered overflow IRQ.
module hpm_counter_bank #(
  parameter int unsigned P_COUNTERS  = 4,
  parameter int unsigned P_EVENTS    = 8,
  parameter int unsigned P_CNT_WIDTH = 64
) (
  input  logic                  s_clk_i,
  input  logic                  s_resetn_i,
  input  logic [P_EVENTS-1:0]   s_event_i,
  input  logic                  s_csr_we_i,
  input  logic [11:0]           s_csr_add_i,
  input  logic [31:0]           s_csr_wdata_i,
  output logic [31:0]           s_csr_rdata_o,
  output logic                  s_csr_hit_o,
  output logic [P_COUNTERS-1:0] s_ovf_o,
  output logic                  s_ovf_irq_o
);

  localparam int unsigned HW = P_CNT_WIDTH - 32;

  localparam logic [11:0] ADD_CNT_LO  = 12'hB03;
  localparam logic [11:0] ADD_CNT_HI  = 12'hB83;
  localparam logic [11:0] ADD_EVENT   = 12'h323;
  localparam logic [11:0] ADD_INHIBIT = 12'h320;
  localparam logic [11:0] ADD_OVF_ST  = 12'h7C0;
  localparam logic [11:0] ADD_OVF_EN  = 12'h7C1;

  logic [P_CNT_WIDTH-1:0] cnt_q  [P_COUNTERS];
  logic [P_CNT_WIDTH-1:0] cnt_d  [P_COUNTERS];
  logic [P_EVENTS-1:0]    mask_q [P_COUNTERS];
  logic [P_EVENTS-1:0]    mask_d [P_COUNTERS];
  logic [P_COUNTERS-1:0]  inh_q, inh_d;
  logic [P_COUNTERS-1:0]  ovf_q, ovf_d;
  logic [P_COUNTERS-1:0]  ovf_en_q, ovf_en_d;
  logic                   irq_q, irq_d;
  logic [P_COUNTERS-1:0]  ovf_set;
  logic [P_COUNTERS-1:0]  ovf_clr;

  always_comb begin
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    inh_d    = inh_q;
    ovf_en_d = ovf_en_q;
    ovf_set  = '0;
    ovf_clr  = '0;

    for (int unsigned k = 0; k < P_COUNTERS; k++) begin
      // A CSR write to either half of a counter suppresses its increment and overflow.
      if (s_csr_we_i && (s_csr_add_i == ADD_CNT_LO + 12'(k))) begin
        cnt_d[k][31:0] = s_csr_wdata_i;
      end else if (s_csr_we_i && (s_csr_add_i == ADD_CNT_HI + 12'(k))) begin
        cnt_d[k][P_CNT_WIDTH-1:32] = s_csr_wdata_i[HW-1:0];
      end else if (!inh_q[k] && (|(s_event_i & mask_q[k]))) begin
        cnt_d[k]   = cnt_q[k] + P_CNT_WIDTH'(1);
        ovf_set[k] = &cnt_q[k];
      end

      if (s_csr_we_i && (s_csr_add_i == ADD_EVENT + 12'(k))) begin
        mask_d[k] = s_csr_wdata_i[P_EVENTS-1:0];
      end
    end

    if (s_csr_we_i && (s_csr_add_i == ADD_INHIBIT)) begin
      inh_d = s_csr_wdata_i[3 +: P_COUNTERS];
    end
    if (s_csr_we_i && (s_csr_add_i == ADD_OVF_EN)) begin
      ovf_en_d = s_csr_wdata_i[P_COUNTERS-1:0];
    end
    if (s_csr_we_i && (s_csr_add_i == ADD_OVF_ST)) begin
      ovf_clr = s_csr_wdata_i[P_COUNTERS-1:0];
    end

    // A fresh overflow wins over a simultaneous write-1-to-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    irq_d = |(ovf_d & ovf_en_q);
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      cnt_q    <= '{default: '0};
      mask_q   <= '{default: '0};
      inh_q    <= '0;
      ovf_q    <= '0;
      ovf_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      inh_q    <= inh_d;
      ovf_q    <= ovf_d;
      ovf_en_q <= ovf_en_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    s_csr_rdata_o = '0;
    s_csr_hit_o   = 1'b0;

    if (s_csr_add_i == ADD_INHIBIT) begin
      s_csr_hit_o                    = 1'b1;
      s_csr_rdata_o[3 +: P_COUNTERS] = inh_q;
    end else if (s_csr_add_i == ADD_OVF_ST) begin
      s_csr_hit_o                     = 1'b1;
      s_csr_rdata_o[P_COUNTERS-1:0]   = ovf_q;
    end else if (s_csr_add_i == ADD_OVF_EN) begin
      s_csr_hit_o                     = 1'b1;
      s_csr_rdata_o[P_COUNTERS-1:0]   = ovf_en_q;
    end

    for (int unsigned k = 0; k < P_COUNTERS; k++) begin
      if (s_csr_add_i == ADD_CNT_LO + 12'(k)) begin
        s_csr_hit_o   = 1'b1;
        s_csr_rdata_o = cnt_q[k][31:0];
      end else if (s_csr_add_i == ADD_CNT_HI + 12'(k)) begin
        s_csr_hit_o           = 1'b1;
        s_csr_rdata_o[HW-1:0] = cnt_q[k][P_CNT_WIDTH-1:32];
      end else if (s_csr_add_i == ADD_EVENT + 12'(k)) begin
        s_csr_hit_o                 = 1'b1;
        s_csr_rdata_o[P_EVENTS-1:0] = mask_q[k];
      end
    end
  end

  assign s_ovf_o     = ovf_q;
  assign s_ovf_irq_o = irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: directed scenarios plus random CSR/event traffic
// compared against an arithmetic model of the counter bank.
module tb_hpm_counter_bank;

  localparam int unsigned P = 4;
  localparam int unsigned E = 8;
  localparam int unsigned W = 64;

  logic          clk;
  logic          resetn;
  logic [E-1:0]  ev_i;
  logic          we_i;
  logic [11:0]   add_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata;
  logic          hit;
  logic [P-1:0]  ovf;
  logic          irq;

  hpm_counter_bank #(
    .P_COUNTERS (P),
    .P_EVENTS   (E),
    .P_CNT_WIDTH(W)
  ) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (resetn),
    .s_event_i    (ev_i),
    .s_csr_we_i   (we_i),
    .s_csr_add_i  (add_i),
    .s_csr_wdata_i(wdata_i),
    .s_csr_rdata_o(rdata),
    .s_csr_hit_o  (hit),
    .s_ovf_o      (ovf),
    .s_ovf_irq_o  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0] cmask;
  logic [31:0] ev_impl, inh_impl, cnt_impl;
  logic [63:0] m_cnt  [P];
  logic [31:0] m_mask [P];
  logic [31:0] m_inh, m_ovf, m_en;
  logic        m_irq;

  task automatic mdl_reset();
    for (int k = 0; k < P; k++) begin
      m_cnt[k]  = '0;
      m_mask[k] = '0;
    end
    m_inh = '0; m_ovf = '0; m_en = '0; m_irq = 1'b0;
  endtask

  task automatic mdl_step(input logic [31:0] ev, input logic we, input logic [11:0] a,
                          input logic [31:0] wd);
    logic [31:0] set;
    logic [31:0] en_old;
    set    = '0;
    en_old = m_en;
    for (int k = 0; k < P; k++) begin
      if (we && a == 12'hB03 + 12'(k))
        m_cnt[k] = {m_cnt[k][63:32], wd};
      else if (we && a == 12'hB83 + 12'(k))
        m_cnt[k] = {wd, m_cnt[k][31:0]} & cmask;
      else if (!m_inh[3+k] && (ev & m_mask[k]) != 0) begin
        if (m_cnt[k] == cmask) begin
          m_cnt[k] = '0;
          set[k]   = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
    end
    for (int k = 0; k < P; k++)
      if (we && a == 12'h323 + 12'(k)) m_mask[k] = wd & ev_impl;
    if (we && a == 12'h320) m_inh = wd & inh_impl;
    if (we && a == 12'h7C1) m_en  = wd & cnt_impl;
    if (we && a == 12'h7C0) m_ovf = m_ovf & ~(wd & cnt_impl);
    m_ovf = m_ovf | set;
    m_irq = (m_ovf & en_old) != 0;
  endtask

  function automatic logic [32:0] mdl_read(input logic [11:0] a);
    if (a == 12'h320) return {1'b1, m_inh};
    if (a == 12'h7C0) return {1'b1, m_ovf};
    if (a == 12'h7C1) return {1'b1, m_en};
    for (int k = 0; k < P; k++) begin
      if (a == 12'hB03 + 12'(k)) return {1'b1, m_cnt[k][31:0]};
      if (a == 12'hB83 + 12'(k)) return {1'b1, m_cnt[k][63:32]};
      if (a == 12'h323 + 12'(k)) return {1'b1, m_mask[k]};
    end
    return 33'd0;
  endfunction

  // One clock: apply inputs, check combinational read, clock, check flags.
  task automatic step(input logic [31:0] ev, input logic we, input logic [11:0] a,
                      input logic [31:0] wd);
    logic [32:0] exp;
    ev_i = ev[E-1:0]; we_i = we; add_i = a; wdata_i = wd;
    #2;
    exp = mdl_read(a);
    check("rdata", {32'd0, rdata}, {32'd0, exp[31:0]});
    check("hit", {63'd0, hit}, {63'd0, exp[32]});
    @(posedge clk);
    mdl_step(ev, we, a, wd);
    #1;
    check("ovf", {60'd0, ovf}, {32'd0, m_ovf});
    check("irq", {63'd0, irq}, {63'd0, m_irq});
  endtask

  // Combinational peek with no events and no write, so no state can change.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp_const);
    logic [32:0] exp;
    ev_i = '0; we_i = 1'b0; add_i = a; wdata_i = '0;
    #1;
    exp = mdl_read(a);
    check(tag, {32'd0, rdata}, {32'd0, exp_const});
    check({tag, "_mdl"}, {31'd0, hit, rdata}, {31'd0, exp});
  endtask

  localparam logic [11:0] ADDRS [18] = '{
    12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
    12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'h7C0, 12'h7C1,
    12'hB07, 12'h327, 12'h000
  };

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    cmask    = {64{1'b1}} >> (64 - W);
    ev_impl  = 32'((64'd1 << E) - 64'd1);
    cnt_impl = 32'((64'd1 << P) - 64'd1);
    inh_impl = cnt_impl << 3;

    resetn = 1'b0; ev_i = '0; we_i = 1'b0; add_i = '0; wdata_i = '0;
    mdl_reset();
    #1;
    rd("rst_c3", 12'hB03, 32'd0);
    rd("rst_inh", 12'h320, 32'd0);
    check("rst_ovf", {60'd0, ovf}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // Basic counting
    step(0, 1, 12'h323, 32'h1);
    repeat (5) step(1, 0, 12'hB03, 0);
    rd("c3_five", 12'hB03, 32'd5);
    rd("c4_zero", 12'hB04, 32'd0);
    rd("c5_zero", 12'hB05, 32'd0);
    rd("c6_zero", 12'hB06, 32'd0);

    // Several selected events in one cycle still count once
    step(0, 1, 12'h324, 32'h6);
    repeat (3) step(6, 0, 12'hB04, 0);
    rd("c4_single_inc", 12'hB04, 32'd3);
    rd("c3_unmasked", 12'hB03, 32'd5);

    // Wrap and overflow
    step(0, 1, 12'hB83, 32'hFFFF_FFFF);
    step(0, 1, 12'hB03, 32'hFFFF_FFFE);
    step(0, 1, 12'h7C1, 32'h1);
    step(1, 0, 12'hB03, 0);
    step(1, 0, 12'hB03, 0);
    check("ovf_wrap", {60'd0, ovf}, 64'h1);
    rd("c3_wrapped_lo", 12'hB03, 32'd0);
    rd("c3_wrapped_hi", 12'hB83, 32'd0);
    step(0, 0, 12'h7C0, 0);
    check("irq_wrap", {63'd0, irq}, 64'd1);
    step(0, 1, 12'h7C0, 32'h1);
    step(0, 0, 12'h7C0, 0);
    check("ovf_cleared", {60'd0, ovf}, 64'd0);
    check("irq_cleared", {63'd0, irq}, 64'd0);

    // Write priority over a concurrent event
    step(1, 1, 12'hB03, 32'h100);
    rd("c3_write_wins", 12'hB03, 32'h100);
    step(1, 0, 12'hB03, 0);
    rd("c3_after_write", 12'hB03, 32'h101);

    // Inhibit
    step(0, 1, 12'h320, 32'h8);
    repeat (3) step(7, 0, 12'h320, 0);
    rd("c3_frozen", 12'hB03, 32'h101);
    rd("c4_running", 12'hB04, 32'd6);
    rd("inh_read", 12'h320, 32'h8);
    step(0, 1, 12'h320, 32'hFFFF_FFFF);
    rd("inh_all", 12'h320, 32'h78);
    step(0, 1, 12'h320, 32'h0);

    // Unimplemented counter index
    rd("b07_rdata", 12'hB07, 32'd0);
    check("b07_hit", {63'd0, hit}, 64'd0);
    step(0, 1, 12'hB07, 32'h1234);
    rd("c3_after_b07", 12'hB03, 32'h101);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      a  = ADDRS[$urandom_range(0, 17)];
      wd = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      step($urandom, ($urandom_range(0, 9) < 2), a, wd);
      if (i == 300) begin
        #3 resetn = 1'b0;
        mdl_reset();
        rd("async_rst_c3", 12'hB03, 32'd0);
        rd("async_rst_c4", 12'hB04, 32'd0);
        rd("async_rst_mask", 12'h323, 32'd0);
        check("async_rst_ovf", {60'd0, ovf}, 64'd0);
        check("async_rst_irq", {63'd0, irq}, 64'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
